// File: rtl/usr_pkg.sv
// Shared mode encodings for universal_shift_register and its helpers.
package usr_pkg;

  typedef logic [2:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 3'b000;
  localparam usr_mode_t MODE_SHL  = 3'b001;
  localparam usr_mode_t MODE_SHR  = 3'b010;
  localparam usr_mode_t MODE_ROL  = 3'b011;
  localparam usr_mode_t MODE_ROR  = 3'b100;
  localparam usr_mode_t MODE_LOAD = 3'b101;

endpackage

// File: rtl/shift_frame_counter.sv
// Counts serial shifts modulo WIDTH; wrap flags the shift that completes a frame.
module shift_frame_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  output logic             wrap,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        count <= wrap ? '0 : count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Width-generic shift/rotate/load register with a WIDTH-shift frame detector,
// usable as either a SIPO or a PISO stage.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [2:0]       mode,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             frame_valid,
  output logic [WIDTH-1:0] frame_data
);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             is_shift;
  logic             is_load;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             wrap;
  logic [CNT_W-1:0] frame_count;
  logic             frame_done;

  always_comb begin
    shift_next = shift_reg;
    unique case (usr_mode_t'(mode))
      MODE_SHL:  shift_next = {shift_reg[WIDTH-2:0], ser_in_lsb};
      MODE_SHR:  shift_next = {ser_in_msb, shift_reg[WIDTH-1:1]};
      MODE_ROL:  shift_next = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]};
      MODE_ROR:  shift_next = {shift_reg[0], shift_reg[WIDTH-1:1]};
      MODE_LOAD: shift_next = par_in;
      default:   shift_next = shift_reg;
    endcase
  end

  assign is_shift = (mode == MODE_SHL) || (mode == MODE_SHR);
  assign is_load  = (mode == MODE_LOAD);
  // Gating inc with en and clear keeps wrap meaningful as "frame completes this edge".
  assign cnt_inc  = en && !clear && is_shift;
  assign cnt_clr  = clear || is_load;

  shift_frame_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .wrap (wrap),
    .count(frame_count)
  );

  assign frame_done = wrap && (frame_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg <= '0;
    end else if (en) begin
      shift_reg <= clear ? '0 : shift_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        frame_data <= shift_next;
      end
    end
  end

  assign par_out     = shift_reg;
  assign ser_out_msb = shift_reg[WIDTH-1];
  assign ser_out_lsb = shift_reg[0];

endmodule
